// File: rtl/vga_frame_reader.sv
// VGA timing generator that reads a centred RGB444 image from the frame-buffer RAM.
// The surround is black. Sync and colour leave the block with the same latency.
module vga_frame_reader #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int IMG_W    = 320,
    parameter int IMG_H    = 240,
    parameter int X_OFS    = 160,
    parameter int Y_OFS    = 120,
    parameter int RD_LAT   = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    output logic [16:0] ram_addr_o,
    output logic        ram_rd_en,
    input  logic [11:0] ram_data,
    output logic        vga_hs,
    output logic        vga_vs,
    output logic [3:0]  vga_r,
    output logic [3:0]  vga_g,
    output logic [3:0]  vga_b,
    output logic        frame_start
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_ACT      = 10'(H_ACTIVE);
    localparam logic [9:0] V_ACT      = 10'(V_ACTIVE);
    localparam logic [9:0] H_SYNC_ON  = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] H_SYNC_OFF = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] V_SYNC_ON  = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] V_SYNC_OFF = 10'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [9:0] X_LO       = 10'(X_OFS);
    localparam logic [9:0] X_HI       = 10'(X_OFS + IMG_W);
    localparam logic [9:0] Y_LO       = 10'(Y_OFS);
    localparam logic [9:0] Y_HI       = 10'(Y_OFS + IMG_H);

    logic [9:0]      h_cnt_r;
    logic [9:0]      v_cnt_r;
    logic            run_r;
    logic            run_s;
    logic [16:0]     ptr_r;
    logic            hs_raw_s;
    logic            vs_raw_s;
    logic            act_raw_s;
    logic            win_raw_s;
    logic            origin_s;
    logic [RD_LAT:0] hs_pipe_r;
    logic [RD_LAT:0] vs_pipe_r;
    logic [RD_LAT:0] act_pipe_r;
    logic [RD_LAT:0] win_pipe_r;
    logic [11:0]     rgb_r;

    // Raw timing flags decoded from the raster position.
    // run_r delays the enable by one clock so a fresh enable always starts at (0,0).
    always_comb begin
        run_s     = en & run_r;
        hs_raw_s  = ~((h_cnt_r >= H_SYNC_ON) && (h_cnt_r < H_SYNC_OFF));
        vs_raw_s  = ~((v_cnt_r >= V_SYNC_ON) && (v_cnt_r < V_SYNC_OFF));
        act_raw_s = (h_cnt_r < H_ACT) && (v_cnt_r < V_ACT);
        win_raw_s = (h_cnt_r >= X_LO) && (h_cnt_r < X_HI) &&
                    (v_cnt_r >= Y_LO) && (v_cnt_r < Y_HI);
        origin_s  = (h_cnt_r == 10'd0) && (v_cnt_r == 10'd0);
    end

    // Raster counters, held at the origin while disabled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_r   <= 1'b0;
            h_cnt_r <= 10'd0;
            v_cnt_r <= 10'd0;
        end else begin
            run_r <= en;
            if (!run_s) begin
                h_cnt_r <= 10'd0;
                v_cnt_r <= 10'd0;
            end else if (h_cnt_r == H_LAST) begin
                h_cnt_r <= 10'd0;
                v_cnt_r <= (v_cnt_r == V_LAST) ? 10'd0 : v_cnt_r + 10'd1;
            end else begin
                h_cnt_r <= h_cnt_r + 10'd1;
                v_cnt_r <= v_cnt_r;
            end
        end
    end

    // Linear read pointer: raster-ordered addresses without a multiplier.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_r <= 17'd0;
        end else if (!run_s || origin_s) begin
            ptr_r <= 17'd0;
        end else if (win_raw_s) begin
            ptr_r <= ptr_r + 17'd1;
        end else begin
            ptr_r <= ptr_r;
        end
    end

    // Stage 1 plus a delay line that lines the flags up with the RAM data.
    // Disabled cycles shift in blank, sync-inactive values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ram_addr_o  <= 17'd0;
            frame_start <= 1'b0;
            hs_pipe_r   <= {(RD_LAT + 1){1'b1}};
            vs_pipe_r   <= {(RD_LAT + 1){1'b1}};
            act_pipe_r  <= {(RD_LAT + 1){1'b0}};
            win_pipe_r  <= {(RD_LAT + 1){1'b0}};
        end else begin
            ram_addr_o  <= run_s ? ptr_r : 17'd0;
            frame_start <= run_s & origin_s;
            hs_pipe_r   <= {hs_pipe_r[RD_LAT-1:0],  run_s ? hs_raw_s  : 1'b1};
            vs_pipe_r   <= {vs_pipe_r[RD_LAT-1:0],  run_s ? vs_raw_s  : 1'b1};
            act_pipe_r  <= {act_pipe_r[RD_LAT-1:0], run_s & act_raw_s};
            win_pipe_r  <= {win_pipe_r[RD_LAT-1:0], run_s & win_raw_s};
        end
    end

    // Output register: sync from the delayed flags, colour only inside the window.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vga_hs <= 1'b1;
            vga_vs <= 1'b1;
            rgb_r  <= 12'h000;
        end else begin
            vga_hs <= hs_pipe_r[RD_LAT];
            vga_vs <= vs_pipe_r[RD_LAT];
            if (act_pipe_r[RD_LAT] && win_pipe_r[RD_LAT]) begin
                rgb_r <= ram_data;
            end else begin
                rgb_r <= 12'h000;
            end
        end
    end

    assign ram_rd_en = win_pipe_r[0];
    assign vga_r     = rgb_r[11:8];
    assign vga_g     = rgb_r[7:4];
    assign vga_b     = rgb_r[3:0];

endmodule

// File: tb/tb_vga_frame_reader.sv
// Directed self-checking bench for vga_frame_reader.
// Uses a reduced-geometry instance plus a default-geometry instance for line timing.
module tb_vga_frame_reader;
    localparam int HT    = 100;
    localparam int VT    = 80;
    localparam int FRAME = HT * VT;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b1;
    logic        en    = 1'b1;
    logic [16:0] ram_addr_o;
    logic        ram_rd_en;
    logic [11:0] ram_data;
    logic        vga_hs, vga_vs, frame_start;
    logic [3:0]  vga_r, vga_g, vga_b;
    logic [16:0] q1, q2;

    logic [16:0] d_addr;
    logic        d_rd_en, d_hs, d_vs, d_fs;
    logic [3:0]  d_r, d_g, d_b;

    int n_chk  = 0;
    int n_fail = 0;

    always #20 clk = ~clk;

    // Two-clock-latency RAM that returns the low 12 address bits.
    always @(posedge clk) begin
        q1 <= ram_addr_o;
        q2 <= q1;
    end
    assign ram_data = q2[11:0];

    vga_frame_reader #(
        .H_ACTIVE(80), .H_FP(4), .H_SYNC(8), .H_BP(8),
        .V_ACTIVE(72), .V_FP(3), .V_SYNC(2), .V_BP(3),
        .IMG_W(64), .IMG_H(64), .X_OFS(8), .Y_OFS(4), .RD_LAT(2)
    ) dut (
        .clk(clk), .rst_n(rst_n), .en(en),
        .ram_addr_o(ram_addr_o), .ram_rd_en(ram_rd_en), .ram_data(ram_data),
        .vga_hs(vga_hs), .vga_vs(vga_vs),
        .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
        .frame_start(frame_start)
    );

    vga_frame_reader dflt (
        .clk(clk), .rst_n(rst_n), .en(en),
        .ram_addr_o(d_addr), .ram_rd_en(d_rd_en), .ram_data(12'h000),
        .vga_hs(d_hs), .vga_vs(d_vs),
        .vga_r(d_r), .vga_g(d_g), .vga_b(d_b),
        .frame_start(d_fs)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    function automatic int wrapf(input int p);
        return (p < 0) ? p + FRAME : p % FRAME;
    endfunction

    function automatic logic s_hs(input int p);
        int h;
        h = wrapf(p) % HT;
        return !(h >= 84 && h < 92);
    endfunction

    function automatic logic s_vs(input int p);
        int v;
        v = wrapf(p) / HT;
        return !(v >= 75 && v < 77);
    endfunction

    function automatic logic s_win(input int p);
        int h, v;
        h = wrapf(p) % HT;
        v = wrapf(p) / HT;
        return (h >= 8) && (h < 72) && (v >= 4) && (v < 68);
    endfunction

    function automatic logic [16:0] s_addr(input int p);
        int h, v;
        h = wrapf(p) % HT;
        v = wrapf(p) / HT;
        return 17'((v - 4) * 64 + (h - 8));
    endfunction

    function automatic logic dflt_hs(input int p);
        int h;
        if (p < 0) return 1'b1;
        h = p % 800;
        return !(h >= 656 && h < 752);
    endfunction

    task automatic wait_fs(input int limit, output int k);
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!frame_start && k < limit);
    endtask

    // Starts on the sample where frame_start is high (t=0 is stage-1 position 0).
    task automatic scan(input int n, input int exp_rd, input bit first, input string tag);
        int n_rd = 0, b_rd = 0, b_addr = 0, b_fs = 0, b_hs = 0, b_vs = 0, b_rgb = 0;
        int n_hs = 0, n_vs = 0, hs_fall = -1, vs_fall = -1, d_bad = 0, d_low = 0;
        logic [16:0] ea, a408, a471, a508, a6771;
        logic [11:0] er, rgb, r410, r411, r412, r474, r475, r6774;
        for (int t = 0; t < n; t++) begin
            if (t > 0) @(negedge clk);
            rgb = {vga_r, vga_g, vga_b};
            if (ram_rd_en !== s_win(t)) b_rd++;
            if (s_win(t)) begin
                ea = s_addr(t);
                if (ram_addr_o !== ea) b_addr++;
            end
            if (ram_rd_en) n_rd++;
            if (frame_start !== (t % FRAME == 0)) b_fs++;
            if (vga_hs !== s_hs(t - 3)) b_hs++;
            if (vga_vs !== s_vs(t - 3)) b_vs++;
            er = 12'h000;
            if (s_win(t - 3)) begin
                ea = s_addr(t - 3);
                er = ea[11:0];
            end
            if (rgb !== er) b_rgb++;
            if (!vga_hs) begin
                n_hs++;
                if (hs_fall < 0) hs_fall = t;
            end
            if (!vga_vs) begin
                n_vs++;
                if (vs_fall < 0) vs_fall = t;
            end
            if (t == 408)  a408  = ram_addr_o;
            if (t == 471)  a471  = ram_addr_o;
            if (t == 508)  a508  = ram_addr_o;
            if (t == 6771) a6771 = ram_addr_o;
            if (t == 410)  r410  = rgb;
            if (t == 411)  r411  = rgb;
            if (t == 412)  r412  = rgb;
            if (t == 474)  r474  = rgb;
            if (t == 475)  r475  = rgb;
            if (t == 6774) r6774 = rgb;
            if (first) begin
                if (d_hs !== dflt_hs(t - 2)) d_bad++;
                if (d_vs !== 1'b1 || d_rd_en !== 1'b0 || d_addr !== 17'd0) d_bad++;
                if ({d_r, d_g, d_b} !== 12'h000 || d_fs !== (t == 0)) d_bad++;
                if (!d_hs) d_low++;
            end
        end
        check({tag, " rd_en pattern"}, b_rd, 0);
        check({tag, " addr sequence"}, b_addr, 0);
        check({tag, " rd_en count"}, n_rd, exp_rd);
        check({tag, " frame_start pattern"}, b_fs, 0);
        check({tag, " hs pattern"}, b_hs, 0);
        check({tag, " vs pattern"}, b_vs, 0);
        check({tag, " rgb pattern"}, b_rgb, 0);
        if (first) begin
            check("first hs fall", hs_fall, 87);
            check("hs low clocks per frame", n_hs, 640);
            check("first vs fall", vs_fall, 7503);
            check("vs low clocks", n_vs, 200);
            check("addr first window pixel", a408, 0);
            check("addr end of first line", a471, 63);
            check("addr start of second line", a508, 64);
            check("addr last pixel", a6771, 4095);
            check("rgb left of window", r410, 12'h000);
            check("rgb addr 0", r411, 12'h000);
            check("rgb addr 1", r412, 12'h001);
            check("rgb addr 63", r474, 12'h03F);
            check("rgb right of window", r475, 12'h000);
            check("rgb addr 4095", r6774, 12'hFFF);
            check("default geometry timing", d_bad, 0);
            check("default hs low clocks in 10 lines", d_low, 960);
        end
    endtask

    initial begin
        int k;
        int bad;
        #5 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("reset hs", vga_hs, 1);
        check("reset vs", vga_vs, 1);
        check("reset rgb", {vga_r, vga_g, vga_b}, 12'h000);
        check("reset rd_en", ram_rd_en, 0);
        check("reset frame_start", frame_start, 0);
        check("reset addr", ram_addr_o, 0);

        rst_n = 1'b1;
        wait_fs(10, k);
        check("frame_start after reset release", k, 2);
        scan(FRAME, 4096, 1'b1, "frame1");
        @(negedge clk);
        check("frame_start period", frame_start, 1);

        scan(4021, 36 * 64 + 13, 1'b0, "frame2 head");
        en  = 1'b0;
        bad = 0;
        for (int s = 1; s <= 1000; s++) begin
            @(negedge clk);
            if (s == 1) begin
                check("en low rd_en next clock", ram_rd_en, 0);
                check("en low addr next clock", ram_addr_o, 0);
            end
            if (s == 4) begin
                check("en low hs within 4", vga_hs, 1);
                check("en low vs within 4", vga_vs, 1);
                check("en low rgb within 4", {vga_r, vga_g, vga_b}, 12'h000);
            end
            if (ram_rd_en || frame_start) bad++;
            if (s >= 4 && (!vga_hs || !vga_vs || {vga_r, vga_g, vga_b} != 12'h000)) bad++;
        end
        check("activity while en low", bad, 0);
        en = 1'b1;
        wait_fs(10, k);
        check("frame_start after en rise", k, 2);
        scan(1000, 384, 1'b0, "after enable");

        repeat (20) @(negedge clk);
        check("mid-window before reset", ram_rd_en, 1);
        rst_n = 1'b0;
        #1;
        check("async reset hs", vga_hs, 1);
        check("async reset vs", vga_vs, 1);
        check("async reset rgb", {vga_r, vga_g, vga_b}, 12'h000);
        check("async reset rd_en", ram_rd_en, 0);
        check("async reset addr", ram_addr_o, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        wait_fs(10, k);
        check("frame_start after second reset", k, 2);
        scan(FRAME, 4096, 1'b0, "post-reset frame");
        @(negedge clk);
        check("frame_start period after reset", frame_start, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/vga_frame_reader.md
Name: vga_frame_reader

Overview:
- Display-side stage downstream of the camera acquisition path.
- Reads the 320x240 RGB444 frame buffer that the acquisition path fills, using the read port of the dual-port RAM.
- Generates 640x480@60 Hz VGA timing from the 25 MHz system clock and places the image in a centred window with a black surround.
- The acquisition path's init_done gates it through `en`, so nothing is displayed until the camera is configured.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (clocks)
- H_SYNC, 96, hsync pulse width (clocks)
- H_BP, 48, horizontal back porch (clocks)
- V_ACTIVE, 480, visible lines
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BP, 33, vertical back porch (lines)
- IMG_W, 320, frame buffer width
- IMG_H, 240, frame buffer height
- X_OFS, 160, first window column
- Y_OFS, 120, first window line
- RD_LAT, 1, RAM read latency in clocks; legal values 1..3

Ports:
- clk  in  1  system clock, 25 MHz; also the pixel clock
- rst_n  in  1  asynchronous active-low reset
- en  in  1  display enable; tie to init_done
- ram_addr_o  out  17  frame buffer read address
- ram_rd_en  out  1  read strobe, one per window pixel
- ram_data  in  12  RAM read data {R[3:0],G[3:0],B[3:0]}, valid RD_LAT clocks after ram_rd_en
- vga_hs  out  1  horizontal sync, active low
- vga_vs  out  1  vertical sync, active low
- vga_r  out  4  red
- vga_g  out  4  green
- vga_b  out  4  blue
- frame_start  out  1  one-clock pulse at the start of each frame

Behaviour:
- Reset values: h_cnt=0, v_cnt=0, ram_addr_o=0, ram_rd_en=0, vga_hs=1, vga_vs=1, RGB=0, frame_start=0, all delay-pipeline stages cleared to the blank/sync-inactive state.
- h_cnt runs 0..H_TOTAL-1, where H_TOTAL = 800. v_cnt increments when h_cnt wraps and runs 0..V_TOTAL-1, where V_TOTAL = 525.
- Interval order on each axis: active, front porch, sync, back porch.
- Raw sync timing:
  - hs low for h in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC), i.e. 656..751.
  - vs low for v in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC), i.e. 490..491, for whole lines.
- Window: X_OFS <= h < X_OFS+IMG_W and Y_OFS <= v < Y_OFS+IMG_H.
- Stage 1 (registered from the counters):
  - ram_rd_en = window.
  - ram_addr_o = current read pointer.
  - The pointer increments by 1 after each window pixel and resets to 0 when h_cnt=0 and v_cnt=0.
  - No multiplier is used. Addresses therefore run 0..76799 in raster order and never exceed IMG_W*IMG_H-1.
- Output stage (registered):
  - Raw hs, vs, active and window flags are delayed 1+RD_LAT clocks so they align with ram_data.
  - vga_hs and vga_vs are registered from the delayed flags.
  - RGB = ram_data if delayed window; 12'h000 if active but outside the window; 0 during blanking.
  - Total latency from counter position to pins: 2+RD_LAT clocks, identical for sync and colour.
- frame_start: registered pulse in the same clock as ram_addr_o would present pixel (0,0), i.e. stage-1 timing. Exactly one pulse per V_TOTAL*H_TOTAL clocks.
- `en` low:
  - Counters and read pointer are synchronously cleared and held at 0.
  - ram_rd_en=0 and frame_start=0 on the next clock.
  - The delay pipeline continues to shift in blank/inactive values, so vga_hs, vga_vs and RGB reach the reset state within 2+RD_LAT clocks.
- `en` rising: the counters start from (0,0) on the next clock and frame_start pulses one clock later. A partial frame is never produced on enable.
- `en` dropping mid-frame: follows the `en` low rule immediately; no frame completion.
- Asynchronous reset mid-frame: all state returns to reset values immediately; after release, operation resumes under `en` as above.
- No backpressure: RAM reads are unconditional, and write/read tearing is accepted at this stage.

Test Plan:
- Reset held, then released with en=1 -> during reset vga_hs=1, vga_vs=1, RGB=0, ram_rd_en=0. First frame_start 2 clocks after release; frame_start period exactly 420000 clocks.
- Line timing, en=1 -> vga_hs low for exactly 96 clocks per 800-clock period. vga_vs low for exactly 1600 clocks, starting 490*800+(2+RD_LAT) clocks after the counters hit (0,0).
- Window addressing -> ram_rd_en high exactly 76800 clocks per frame, 320 per line on lines 120..359. First address 0 at (h=160,v=120); address 319 at (479,120); address 320 at (160,121); last address 76799 at (479,359).
- Data alignment, RD_LAT=2, RAM model returning addr[11:0] -> at the first visible window pixel RGB=0x000; at address 1 RGB=0x001; at address 4095 RGB=0xFFF. Pixels outside the window and all blanking show 0x000.
- `en` dropped at line 200, held low 1000 clocks, then raised -> within 4 clocks all outputs are at reset values and no reads occur while low. After raising, frame_start pulses 2 clocks later and addressing restarts at 0.
- rst_n asserted mid-window -> outputs return to reset values asynchronously. After release, the next frame reads addresses 0..76799 completely.
